// File: rtl/uart_rx_set_config_pkg.sv
// Shared definitions for the motor configuration receiver: frame header,
// B1 field positions and the state types of the byte and frame machines.
package motoro3_cfg_pkg;

   localparam logic [7:0] CFG_HDR = 8'h55;

   // B1 layout: [7] start, [6] invOrStop, [5:2] ignored, [1:0] freq[9:8]
   localparam int B1_START    = 7;
   localparam int B1_INV      = 6;
   localparam int B1_FREQ_MSB = 1;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [1:0] {
      P_HUNT,
      P_GET1,
      P_GET2,
      P_GETSUM
   } prs_state_t;

endpackage

// File: rtl/uart_rx_set_config_if.sv
// Pin bundle of the configuration receiver.
//   uRx          serial input, idles high
//   m3freq/m3start/m3invOrStop  motor-control settings
//   cfgStrobe/cfgCnt            apply pulse and accepted-frame count
//   frameErr/sumErr/gapErr      one-cycle error pulses
// slave: the receiver; master: whoever drives the line and watches results.
interface uart_rx_set_config_if;
   logic       uRx;
   logic [9:0] m3freq;
   logic       m3start;
   logic       m3invOrStop;
   logic       cfgStrobe;
   logic [7:0] cfgCnt;
   logic       frameErr;
   logic       sumErr;
   logic       gapErr;

   modport master (
      output uRx,
      input  m3freq, m3start, m3invOrStop, cfgStrobe, cfgCnt,
      input  frameErr, sumErr, gapErr
   );

   modport slave (
      input  uRx,
      output m3freq, m3start, m3invOrStop, cfgStrobe, cfgCnt,
      output frameErr, sumErr, gapErr
   );
endinterface

// File: rtl/uart_rx_set_config_byte.sv
// 8N1 byte receiver: two-flop synchroniser, start-bit qualification,
// LSB-first data sampling and stop-bit check.
//   clk, rst     clock, synchronous active-high reset
//   rx_pin       asynchronous serial line
//   byte_valid   one-cycle pulse, byte_data holds the received byte
//   frame_err    one-cycle pulse when the stop bit is sampled low
//
// state    | meaning
// RX_IDLE  | waiting for a 1->0 edge on the synchronised line
// RX_START | half bit-time wait, then recheck that the line is still low
// RX_DATA  | one sample per bit-time, 8 bits
// RX_STOP  | one bit-time wait, then sample the stop bit
module uart_rx_byte
   import motoro3_cfg_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_pin,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);

   rx_state_t     state, state_nxt;
   logic          sync1, sync2, prev;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic          valid_nxt, ferr_nxt;

   assign byte_data = shreg;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1      <= 1'b1;
         sync2      <= 1'b1;
         prev       <= 1'b1;
         state      <= RX_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sync1      <= rx_pin;
         sync2      <= sync1;
         prev       <= sync2;
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         bit_idx    <= bit_idx_nxt;
         shreg      <= shreg_nxt;
         byte_valid <= valid_nxt;
         frame_err  <= ferr_nxt;
      end
   end

   // Counters are loaded with N-1 so the terminal-count cycle is the sample point.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      valid_nxt   = 1'b0;
      ferr_nxt    = 1'b0;
      unique case (state)
         RX_IDLE: begin
            if (prev && !sync2) begin
               state_nxt = RX_START;
               cnt_nxt   = HALF_LD;
            end
         end
         RX_START: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else if (!sync2) begin
               state_nxt   = RX_DATA;
               cnt_nxt     = FULL_LD;
               bit_idx_nxt = '0;
            end else begin
               state_nxt = RX_IDLE;
            end
         end
         RX_DATA: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               shreg_nxt = {sync2, shreg[7:1]};
               cnt_nxt   = FULL_LD;
               if (bit_idx == 3'd7) state_nxt = RX_STOP;
               else                 bit_idx_nxt = bit_idx + 3'd1;
            end
         end
         RX_STOP: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               valid_nxt = sync2;
               ferr_nxt  = !sync2;
               state_nxt = RX_IDLE;
            end
         end
         default: state_nxt = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_rx_set_config.sv
// Configuration frame receiver for the three-phase motor block.
// Parses 0x55, B1, B2, SUM frames from the UART byte stream and applies
// freq/start/invOrStop atomically when SUM = 0x55 ^ B1 ^ B2.
//   clk, rst   10 MHz motor clock, synchronous active-high reset
//   cfg        pin bundle (slave side): uRx in, settings and pulses out
//
// state    | meaning
// P_HUNT   | waiting for the 0x55 header
// P_GET1   | expecting B1 (start, invOrStop, freq[9:8])
// P_GET2   | expecting B2 (freq[7:0])
// P_GETSUM | expecting SUM; apply on match, sumErr otherwise
module uart_rx_set_config
   import motoro3_cfg_pkg::*;
#(
   parameter int         CLKS_PER_BIT = 87,
   parameter int         GAP_BITS     = 20,
   parameter logic [9:0] FREQ_RESET   = 10'd0
) (
   input logic                 clk,
   input logic                 rst,
   uart_rx_set_config_if.slave cfg
);

   localparam int GAP_LIMIT = GAP_BITS * CLKS_PER_BIT;
   localparam int GW        = $clog2(GAP_LIMIT + 1);
   localparam logic [GW-1:0] GAP_LD = GW'(GAP_LIMIT);

   logic       rx_valid, rx_ferr;
   logic [7:0] rx_data;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rx_pin     (cfg.uRx),
      .byte_valid (rx_valid),
      .byte_data  (rx_data),
      .frame_err  (rx_ferr)
   );

   assign cfg.frameErr = rx_ferr;

   prs_state_t    pstate, pstate_nxt;
   logic [GW-1:0] gap_cnt, gap_nxt;
   logic [7:0]    sum_acc, sum_nxt;
   logic          f_start, start_nxt, f_inv, inv_nxt;
   logic [1:0]    f_hi, hi_nxt;
   logic [7:0]    f_lo, lo_nxt;
   logic          apply, sum_bad, timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         pstate          <= P_HUNT;
         gap_cnt         <= GAP_LD;
         sum_acc         <= '0;
         f_start         <= 1'b0;
         f_inv           <= 1'b0;
         f_hi            <= '0;
         f_lo            <= '0;
         cfg.m3freq      <= FREQ_RESET;
         cfg.m3start     <= 1'b0;
         cfg.m3invOrStop <= 1'b0;
         cfg.cfgCnt      <= '0;
         cfg.cfgStrobe   <= 1'b0;
         cfg.sumErr      <= 1'b0;
         cfg.gapErr      <= 1'b0;
      end else begin
         pstate  <= pstate_nxt;
         gap_cnt <= gap_nxt;
         sum_acc <= sum_nxt;
         f_start <= start_nxt;
         f_inv   <= inv_nxt;
         f_hi    <= hi_nxt;
         f_lo    <= lo_nxt;
         if (apply) begin
            cfg.m3freq      <= {f_hi, f_lo};
            cfg.m3start     <= f_start;
            cfg.m3invOrStop <= f_inv;
            cfg.cfgCnt      <= cfg.cfgCnt + 8'd1;
         end
         cfg.cfgStrobe <= apply;
         cfg.sumErr    <= sum_bad;
         cfg.gapErr    <= timeout;
      end
   end

   // The checksum is accumulated byte by byte so the ignored B1 bits still
   // take part in it without being stored.
   always_comb begin
      pstate_nxt = pstate;
      gap_nxt    = gap_cnt;
      sum_nxt    = sum_acc;
      start_nxt  = f_start;
      inv_nxt    = f_inv;
      hi_nxt     = f_hi;
      lo_nxt     = f_lo;
      apply      = 1'b0;
      sum_bad    = 1'b0;
      timeout    = 1'b0;

      if (pstate == P_HUNT) begin
         gap_nxt = GAP_LD;
      end else if (gap_cnt == '0) begin
         timeout = 1'b1;
         gap_nxt = GAP_LD;
      end else if (rx_valid) begin
         gap_nxt = GAP_LD;
      end else begin
         gap_nxt = gap_cnt - 1'b1;
      end

      // A timeout wins over a byte arriving in the same cycle; that byte is dropped.
      if (timeout || (rx_ferr && pstate != P_HUNT)) begin
         pstate_nxt = P_HUNT;
      end else if (rx_valid) begin
         unique case (pstate)
            P_HUNT: begin
               if (rx_data == CFG_HDR) begin
                  pstate_nxt = P_GET1;
                  sum_nxt    = CFG_HDR;
               end
            end
            P_GET1: begin
               start_nxt  = rx_data[B1_START];
               inv_nxt    = rx_data[B1_INV];
               hi_nxt     = rx_data[B1_FREQ_MSB -: 2];
               sum_nxt    = sum_acc ^ rx_data;
               pstate_nxt = P_GET2;
            end
            P_GET2: begin
               lo_nxt     = rx_data;
               sum_nxt    = sum_acc ^ rx_data;
               pstate_nxt = P_GETSUM;
            end
            P_GETSUM: begin
               apply      = (rx_data == sum_acc);
               sum_bad    = (rx_data != sum_acc);
               pstate_nxt = P_HUNT;
            end
            default: pstate_nxt = P_HUNT;
         endcase
      end
   end

endmodule
